mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single-port synchronous memory between the instruction-fetch requester (I) and the load/store requester (D) inside the memory-core wrapper. It issues at most one memory command per cycle and grants D by priority, with a starvation counter that forces an I grant. A latency-matched tag pipeline routes each read response back to its owner.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- MEM_LAT, 1, memory read latency in cycles (1 or 2)
- D_STREAK_MAX, 4, maximum consecutive D grants while I is waiting

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until granted
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch command accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  load/store request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  load/store command accepted this cycle
- d_rvalid  out  1  load data valid; never asserted for stores
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read command

## Operation
- Grant decision, combinational within the cycle:
  - Neither requester active: no grant.
  - Only one requester active: that requester is granted.
  - Both requesters active: D is granted unless streak == D_STREAK_MAX, in which case I is granted.
- At most one of i_gnt and d_gnt is high in any cycle.
- The granted requester's command drives mem_* in the same cycle, with mem_en=1.
- I commands are always reads: mem_we=0, mem_be all ones.
- When mem_en=0, mem_addr, mem_wdata and mem_be are don't-care, and mem_we=0.
- streak counter, width clog2(D_STREAK_MAX+1):
  - Increments on a D grant while i_req=1.
  - Clears on any I grant.
  - Clears whenever i_req=0.
  - Saturates at D_STREAK_MAX.
- Tag pipeline: MEM_LAT stages, each {valid, owner}.
  - Stage 0 captures {1, I} on an I grant, {1, D} on a D load grant, and {0, x} otherwise. A store never produces a response.
  - The last stage drives i_rvalid or d_rvalid, selected by owner.
  - mem_rdata is routed unregistered to both rdata outputs; only the rvalids qualify it.
- Requesters must hold req and command fields stable until granted. The arbiter does not register commands.
- Reset (rst=1 at a rising edge):
  - streak and all tag-valid bits clear.
  - i_gnt, d_gnt, mem_en, mem_we and both rvalids are forced 0 while rst=1, regardless of req.
  - Responses for commands issued before reset are dropped, even if the memory returns data.

## Timing
- A grant occurs in the same cycle as the request: zero added latency.
- Read data and rvalid appear exactly MEM_LAT cycles after the grant cycle.
- Back-to-back grants every cycle are allowed. Responses return in grant order, one per cycle at most.
- Simultaneous requests with streak < D_STREAK_MAX: D wins, and I waits at most D_STREAK_MAX cycles.
- First cycle after rst deasserts: grants are legal immediately.

## Structure
- A shared package mem_arb_pkg holds:
  - The owner enum (OWN_I, OWN_D).
  - The tag struct {valid, owner}.
- One sub-module, arb_tag_pipe, parameterised by MEM_LAT. It contains the shift register of tags and the rvalid decode.
- Top level contains the grant logic, the streak counter and the mem_* muxing.

## Test plan
- I-only fetch at 0x100, MEM_LAT=1:
  - i_gnt=1 the same cycle; mem_addr=0x100, mem_we=0.
  - Next cycle: i_rvalid=1 with the memory word; d_rvalid=0.
- D store to 0x200 with d_be=4'b0011 and d_wdata=0xDEADBEEF:
  - Same cycle: mem_we=1, mem_be=0011.
  - No rvalid is ever asserted for it.
- i_req and d_req both held continuously with D_STREAK_MAX=4:
  - Grant sequence is D,D,D,D,I repeating.
  - i_gnt is never delayed more than 4 cycles.
- MEM_LAT=2, alternating I load and D load every cycle:
  - Each response arrives 2 cycles after its grant on the correct rvalid, in order.
- rst asserted the cycle after a D load grant:
  - No d_rvalid is asserted.
  - Outputs are 0 during rst.
  - A fresh I request granted on the first post-reset cycle.
- Both requests idle for 3 cycles:
  - mem_en=0 and both gnt signals 0 throughout.
  - streak reads 0 afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared owner enum and response-tag type for the memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_I};

endpackage

`default_nettype wire

// File: rtl/arb_tag_pipe.sv
// ============================================================================
// Module   : arb_tag_pipe
// Brief    : Latency-matched tag shift register; decodes the last stage into
//            per-requester read-valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output logic i_rvalid,
  output logic d_rvalid
);

  tag_t [MEM_LAT-1:0] stage_q;
  tag_t [MEM_LAT-1:0] stage_d;
  tag_t               last_tag;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int k = 1; k < MEM_LAT; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Clearing every stage on reset drops responses to commands issued earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        stage_q[k] <= TAG_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    last_tag = stage_q[MEM_LAT-1];
    i_rvalid = !rst && last_tag.valid && (last_tag.owner == OWN_I);
    d_rvalid = !rst && last_tag.valid && (last_tag.owner == OWN_D);
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Single-port memory arbiter between fetch (I) and load/store (D),
//            D-priority with a starvation streak that forces an I grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int D_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int                  STREAK_W   = $clog2(D_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(D_STREAK_MAX);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                grant_i;
  logic                grant_d;
  tag_t                tag_issue;

  // D wins ties until it has been granted D_STREAK_MAX times over a waiting I.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (d_req && !(i_req && (streak_q == STREAK_CAP))) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!i_req || grant_i) begin
      streak_d = '0;
    end else if (grant_d && (streak_q != STREAK_CAP)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  always_comb begin
    mem_en    = grant_i | grant_d;
    mem_we    = grant_d & d_we;
    mem_be    = grant_d ? d_be : '1;
    mem_addr  = grant_d ? d_addr : i_addr;
    mem_wdata = d_wdata;
  end

  always_comb begin
    tag_issue.valid = grant_i | (grant_d & ~d_we);
    tag_issue.owner = grant_d ? OWN_D : OWN_I;
  end

  assign i_gnt   = grant_i;
  assign d_gnt   = grant_d;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (tag_issue),
    .i_rvalid (i_rvalid),
    .d_rvalid (d_rvalid)
  );

endmodule

`default_nettype wire
